sram_req_ctrl: RTL and testbench

- Initiator-side controller for the single-port 32-bit OpenRAM macro (csb/web/addr/din/dout, inputs captured on posedge, array accessed on the following negedge).
- Converts a valid/ready request stream from the core's instruction/data path into legal SRAM port cycles, including byte-masked writes via read-modify-write.
- Returns exactly one in-order response per request through a small buffered valid/ready channel.

---
 rtl/sram_ctrl_pkg.sv | 27 ++
 rtl/sram_rsp_fifo.sv | 46 ++++
 rtl/sram_req_ctrl.sv | 119 +++++++++++
 tb/tb_sram_req_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared types and helpers for the OpenRAM request controller.
package sram_ctrl_pkg;

    localparam int SRAM_DW  = 32;
    localparam int BE_WIDTH = SRAM_DW / 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RMW_MERGE = 2'd1,
        RMW_WR    = 2'd2
    } state_t;

    // Byte lane i comes from new_w when be[i] is set, otherwise from old_w.
    function automatic logic [SRAM_DW-1:0] byte_merge(
        input logic [BE_WIDTH-1:0] be,
        input logic [SRAM_DW-1:0]  new_w,
        input logic [SRAM_DW-1:0]  old_w
    );
        logic [SRAM_DW-1:0] m;
        m = old_w;
        for (int i = 0; i < BE_WIDTH; i++) begin
            if (be[i]) m[i*8 +: 8] = new_w[i*8 +: 8];
        end
        return m;
    endfunction

endpackage

// File: rtl/sram_rsp_fifo.sv
// In-order response buffer; the producer guarantees it is never pushed while full.
module sram_rsp_fifo #(
    parameter  int DATA_WIDTH = 32,
    parameter  int RSP_DEPTH  = 2,
    localparam int CW         = $clog2(RSP_DEPTH + 1),
    localparam int PW         = $clog2(RSP_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  rd_ready,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [CW-1:0]         count
);

    logic [DATA_WIDTH-1:0] mem [RSP_DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic                  pop;

    assign rd_valid = (count != '0);
    assign pop      = rd_valid && rd_ready;
    assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < RSP_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= nxt(wr_ptr);
            end
            if (pop) rd_ptr <= nxt(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: rtl/sram_req_ctrl.sv
// Valid/ready request front end for a single-port OpenRAM macro, with
// read-modify-write for byte-masked stores and a buffered in-order response path.
module sram_req_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int RSP_DEPTH  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [DATA_WIDTH/8-1:0] req_be,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    sram_csb,
    output logic                    sram_web,
    output logic [ADDR_WIDTH-1:0]   sram_addr,
    output logic [DATA_WIDTH-1:0]   sram_din,
    input  logic [DATA_WIDTH-1:0]   sram_dout
);

    localparam int BW = DATA_WIDTH / 8;
    localparam int CW = $clog2(RSP_DEPTH + 1);

    state_t                state;
    logic                  pending_q, rd_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [BW-1:0]         be_q;
    logic [DATA_WIDTH-1:0] wdata_q, merged_q, push_data;
    logic [CW-1:0]         count;
    logic [CW:0]           occ, room;
    logic                  hs, full_be, partial, pending, pop;

    assign full_be   = &req_be;
    assign partial   = req_we && (req_be != '0) && !full_be;
    // pending doubles as the FIFO push: every access resolves one edge later.
    assign pending   = pending_q || (state == RMW_WR);
    assign pop       = rsp_valid && rsp_ready;
    assign occ       = (CW+1)'(count) + (CW+1)'(pending);
    assign room      = (CW+1)'(RSP_DEPTH) + (CW+1)'(pop);
    assign req_ready = rst_n && (state == IDLE) && (occ < room);
    assign hs        = req_valid && req_ready;
    assign push_data = rd_q ? sram_dout : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pending_q <= 1'b0;
            rd_q      <= 1'b0;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            merged_q  <= '0;
        end else begin
            pending_q <= hs && !partial;
            rd_q      <= hs && !req_we;
            case (state)
                IDLE: begin
                    if (hs && partial) begin
                        state   <= RMW_MERGE;
                        addr_q  <= req_addr;
                        be_q    <= req_be;
                        wdata_q <= req_wdata;
                    end
                end
                RMW_MERGE: begin
                    merged_q <= byte_merge(be_q, wdata_q, sram_dout);
                    state    <= RMW_WR;
                end
                RMW_WR:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Issue cycles drive the macro straight from the request so a read can
    // follow a write on the very next edge.
    always_comb begin
        sram_csb  = 1'b1;
        sram_web  = 1'b1;
        sram_addr = req_addr;
        sram_din  = req_wdata;
        case (state)
            IDLE: begin
                sram_csb = !(hs && (!req_we || (req_be != '0)));
                sram_web = !(hs && req_we && full_be);
            end
            RMW_MERGE: sram_addr = addr_q;
            RMW_WR: begin
                sram_csb  = 1'b0;
                sram_web  = 1'b0;
                sram_addr = addr_q;
                sram_din  = merged_q;
            end
            default: ;
        endcase
    end

    sram_rsp_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .RSP_DEPTH  (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (pending),
        .push_data (push_data),
        .rd_ready  (rsp_ready),
        .rd_valid  (rsp_valid),
        .rd_data   (rsp_rdata),
        .count     (count)
    );

endmodule

// File: tb/tb_sram_req_ctrl.sv
// Bench for sram_req_ctrl with a behavioural OpenRAM-style macro and an
// order-based memory/response scoreboard.
module tb_sram_req_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we;
    logic [3:0]  req_be;
    logic [9:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic        sram_csb, sram_web;
    logic [9:0]  sram_addr;
    logic [31:0] sram_din;
    logic [31:0] sram_dout = 32'h0;

    sram_req_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .RSP_DEPTH(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_be    (req_be),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .sram_csb  (sram_csb),
        .sram_web  (sram_web),
        .sram_addr (sram_addr),
        .sram_din  (sram_din),
        .sram_dout (sram_dout)
    );

    always #5 clk = ~clk;

    // Macro model: port captured on posedge, array accessed on the following negedge.
    logic [31:0] sram_mem [1024];
    logic        csb_r = 1'b1, web_r = 1'b1;
    logic [9:0]  addr_r = '0;
    logic [31:0] din_r = '0;
    always @(posedge clk) begin
        csb_r  <= sram_csb;
        web_r  <= sram_web;
        addr_r <= sram_addr;
        din_r  <= sram_din;
    end
    always @(negedge clk) begin
        if (!csb_r) begin
            if (!web_r) sram_mem[addr_r] <= din_r;
            else        sram_dout        <= sram_mem[addr_r];
        end
    end

    int n_chk = 0, n_pass = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Reference model: memory updated in acceptance order, one expected response per accept.
    logic [31:0] refmem [1024];
    logic [31:0] exp_q[$];
    int          rmw_busy = 0;
    bit          prev_stall = 0;
    logic [31:0] prev_data = '0;
    bit          sb_en = 1;

    // Observation records used by the directed sequences.
    int          cyc = 0;
    int          csb_lo, rdy_lo;
    bit          web_q[$];
    logic [31:0] got_q[$];
    int          got_t[$], acc_t[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            rmw_busy   = 0;
            prev_stall = 0;
        end else begin
            if (!sram_csb) begin csb_lo++; web_q.push_back(sram_web); end
            if (req_valid && !req_ready) rdy_lo++;
            if (rsp_valid && rsp_ready) begin got_q.push_back(rsp_rdata); got_t.push_back(cyc); end
            if (req_valid && req_ready) acc_t.push_back(cyc);
            if (sb_en) begin
                int pop, occ;
                pop = (rsp_valid && rsp_ready) ? 1 : 0;
                occ = exp_q.size() - pop;
                chk("req_ready", 32'(req_ready), 32'((rmw_busy == 0) && (occ < 2)));
                if (prev_stall) begin
                    chk("rsp_hold_valid", 32'(rsp_valid), 32'h1);
                    chk("rsp_hold_data", rsp_rdata, prev_data);
                end
                if (pop == 1) begin
                    if (exp_q.size() == 0) chk("rsp_unexpected", 32'(rsp_valid), 32'h0);
                    else chk("rsp_data", rsp_rdata, exp_q.pop_front());
                end
                if (req_valid && req_ready) begin
                    if (req_we) begin
                        for (int b = 0; b < 4; b++)
                            if (req_be[b]) refmem[req_addr][b*8 +: 8] = req_wdata[b*8 +: 8];
                        exp_q.push_back(32'h0);
                        if (req_be != 4'h0 && req_be != 4'hF) rmw_busy = 2;
                    end else begin
                        exp_q.push_back(refmem[req_addr]);
                    end
                end else if (rmw_busy > 0) begin
                    rmw_busy--;
                end
                prev_stall = rsp_valid && !rsp_ready;
                prev_data  = rsp_rdata;
            end
        end
    end

    task automatic clear_mon();
        csb_lo = 0; rdy_lo = 0;
        web_q.delete(); got_q.delete(); got_t.delete(); acc_t.delete();
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send(input bit we, input bit [3:0] be, input bit [9:0] a, input bit [31:0] d);
        bit took = 0;
        req_valid = 1'b1; req_we = we; req_be = be; req_addr = a; req_wdata = d;
        for (int k = 0; k < 50 && !took; k++) begin
            #7; took = req_ready;
            tick();
        end
        if (!took) begin chk("send_timeout", 32'(took), 32'h1); req_valid = 1'b0; end
    endtask

    typedef struct {
        bit        we;
        bit [3:0]  be;
        bit [9:0]  addr;
        bit [31:0] wdata;
        bit [31:0] exp_rdata;
        int        exp_csb;
    } vec_t;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vec_t        vt [12];
        logic [31:0] exp8 [8];
        logic [31:0] v9, v12;
        bit          took;

        vt[0]  = '{1, 4'hF, 10'd20, 32'h01234567, 32'h00000000, 1};
        vt[1]  = '{0, 4'h0, 10'd20, 32'h0,        32'h01234567, 1};
        vt[2]  = '{1, 4'h3, 10'd20, 32'hFFFFAAAA, 32'h00000000, 2};
        vt[3]  = '{0, 4'h0, 10'd20, 32'h0,        32'h0123AAAA, 1};
        vt[4]  = '{1, 4'hC, 10'd20, 32'h55660000, 32'h00000000, 2};
        vt[5]  = '{0, 4'h0, 10'd20, 32'h0,        32'h5566AAAA, 1};
        vt[6]  = '{1, 4'h0, 10'd20, 32'hFFFFFFFF, 32'h00000000, 0};
        vt[7]  = '{0, 4'h0, 10'd20, 32'h0,        32'h5566AAAA, 1};
        vt[8]  = '{1, 4'hF, 10'd21, 32'h00000000, 32'h00000000, 1};
        vt[9]  = '{1, 4'h1, 10'd21, 32'hFFFFFF80, 32'h00000000, 2};
        vt[10] = '{1, 4'hE, 10'd21, 32'h12345600, 32'h00000000, 2};
        vt[11] = '{0, 4'h0, 10'd21, 32'h0,        32'h12345680, 1};

        for (int i = 0; i < 1024; i++) begin
            sram_mem[i] = $urandom;
            refmem[i]   = sram_mem[i];
        end

        // Reset state, with a read request already presented.
        rst_n = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_be = 4'h0;
        req_addr = 10'd0; req_wdata = 32'h0; rsp_ready = 1'b1;
        tick(); #6;
        chk("rst_csb", 32'(sram_csb), 32'h1);
        chk("rst_web", 32'(sram_web), 32'h1);
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        tick();
        req_valid = 1'b0; rst_n = 1'b1;
        idle(2);

        // Full write then read on the next cycle.
        clear_mon();
        send(1, 4'hF, 10'd5, 32'hDEADBEEF);
        send(0, 4'h0, 10'd5, 32'h0);
        idle(6);
        chk("wr_rd_csb_cycles", 32'(csb_lo), 32'd2);
        chk("wr_rd_nrsp", 32'(got_q.size()), 32'd2);
        if (got_q.size() == 2) begin
            chk("wr_rd_ack", got_q[0], 32'h0);
            chk("wr_rd_data", got_q[1], 32'hDEADBEEF);
        end

        // Partial write over a known word, read following immediately.
        send(1, 4'hF, 10'd7, 32'h11223344);
        idle(4);
        clear_mon();
        send(1, 4'b0101, 10'd7, 32'hAABBCCDD);
        send(0, 4'h0, 10'd7, 32'h0);
        idle(6);
        chk("rmw_csb_cycles", 32'(web_q.size()), 32'd3);
        if (web_q.size() == 3) begin
            chk("rmw_web_rd", 32'(web_q[0]), 32'h1);
            chk("rmw_web_wr", 32'(web_q[1]), 32'h0);
            chk("rmw_web_next_rd", 32'(web_q[2]), 32'h1);
        end
        chk("rmw_ready_low", 32'(rdy_lo), 32'd2);
        if (acc_t.size() == 2) chk("rmw_accept_gap", 32'(acc_t[1] - acc_t[0]), 32'd3);
        chk("rmw_nrsp", 32'(got_q.size()), 32'd2);
        if (got_q.size() == 2) begin
            chk("rmw_ack", got_q[0], 32'h0);
            chk("rmw_merged", got_q[1], 32'h11BB33DD);
        end

        // Table-driven isolated transactions.
        for (int i = 0; i < 12; i++) begin
            clear_mon();
            send(vt[i].we, vt[i].be, vt[i].addr, vt[i].wdata);
            idle(5);
            chk("vec_csb_cycles", 32'(csb_lo), 32'(vt[i].exp_csb));
            if (got_q.size() == 1) chk("vec_rdata", got_q[0], vt[i].exp_rdata);
            else chk("vec_nrsp", 32'(got_q.size()), 32'd1);
        end

        // Back-to-back reads of 0..7.
        clear_mon();
        for (int a = 0; a < 8; a++) exp8[a] = refmem[a];
        for (int a = 0; a < 8; a++) send(0, 4'h0, 10'(a), 32'h0);
        idle(6);
        chk("b2b_naccept", 32'(acc_t.size()), 32'd8);
        if (acc_t.size() == 8) chk("b2b_accept_span", 32'(acc_t[7] - acc_t[0]), 32'd7);
        chk("b2b_nrsp", 32'(got_q.size()), 32'd8);
        for (int a = 0; a < 8 && a < got_q.size(); a++) chk("b2b_data", got_q[a], exp8[a]);
        if (got_t.size() > 0 && acc_t.size() > 0)
            chk("b2b_first_latency", 32'(got_t[0] - acc_t[0]), 32'd2);

        // Backpressure: only RSP_DEPTH reads accepted while rsp_ready is low.
        clear_mon();
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_be = 4'h0; req_addr = 10'd10; req_wdata = 32'h0;
        for (int k = 0; k < 8; k++) begin
            #7; took = req_valid && req_ready;
            tick();
            if (took) req_addr = req_addr + 10'd1;
        end
        chk("stall_naccept", 32'(acc_t.size()), 32'd2);
        chk("stall_ready", 32'(req_ready), 32'h0);
        chk("stall_rsp_valid", 32'(rsp_valid), 32'h1);
        req_valid = 1'b0; rsp_ready = 1'b1;
        idle(5);
        chk("stall_nrsp", 32'(got_q.size()), 32'd2);
        if (got_q.size() == 2) begin
            chk("stall_data0", got_q[0], refmem[10]);
            chk("stall_data1", got_q[1], refmem[11]);
        end

        // Write with no byte enables touches nothing.
        v9 = refmem[9];
        clear_mon();
        send(1, 4'h0, 10'd9, 32'hFFFFFFFF);
        idle(4);
        chk("be0_csb_cycles", 32'(csb_lo), 32'd0);
        chk("be0_nrsp", 32'(got_q.size()), 32'd1);
        if (got_q.size() == 1) begin
            chk("be0_ack", got_q[0], 32'h0);
            chk("be0_latency", 32'(got_t[0] - acc_t[0]), 32'd2);
        end
        clear_mon();
        send(0, 4'h0, 10'd9, 32'h0);
        idle(4);
        if (got_q.size() == 1) chk("be0_mem", got_q[0], v9);
        else chk("be0_rd_nrsp", 32'(got_q.size()), 32'd1);

        // Randomized traffic against the scoreboard.
        took = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (!req_valid || took) begin
                int r;
                req_valid = ($urandom_range(0, 3) != 0);
                req_we    = $urandom_range(0, 1) == 1;
                r         = $urandom_range(0, 3);
                req_be    = (r == 0) ? 4'hF : (r == 1) ? 4'h0 : 4'($urandom_range(1, 14));
                req_addr  = 10'($urandom_range(0, 7));
                req_wdata = $urandom;
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            #7; took = req_valid && req_ready;
            tick();
        end
        req_valid = 1'b0; rsp_ready = 1'b1;
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
        chk("drain_outstanding", 32'(exp_q.size()), 32'd0);
        tick();
        chk("drain_rsp_valid", 32'(rsp_valid), 32'h0);

        // Reset while a partial write's read is in flight and a response is buffered.
        sb_en = 0;
        v12 = refmem[12];
        rsp_ready = 1'b0;
        send(0, 4'h0, 10'd13, 32'h0);
        send(1, 4'b0011, 10'd12, 32'hCAFEF00D);
        req_valid = 1'b0;
        #2; rst_n = 1'b0;
        #1;
        chk("rmw_rst_csb", 32'(sram_csb), 32'h1);
        chk("rmw_rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rmw_rst_ready", 32'(req_ready), 32'h0);
        tick();
        chk("rmw_rst_csb_hold", 32'(sram_csb), 32'h1);
        chk("rmw_rst_web_hold", 32'(sram_web), 32'h1);
        #1; rst_n = 1'b1;
        idle(1);
        sb_en = 1;
        rsp_ready = 1'b1;
        clear_mon();
        send(0, 4'h0, 10'd12, 32'h0);
        idle(5);
        chk("rmw_rst_nrsp", 32'(got_q.size()), 32'd1);
        if (got_q.size() == 1) chk("rmw_rst_word_kept", got_q[0], v12);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
